// File: rtl/gtfwizard_mac_tx_rst_pkg.sv
// Shared types and helpers for the GTF TX reset sequencer: state encoding,
// per-state reset-pin levels and the shared wait-counter width.
package gtfwizard_mac_tx_rst_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT  = 3'd0,
        ST_PISO_REL  = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_PMA_HOLD  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAIL      = 3'd6
    } tx_state_e;

    // Bit order is {GTTXRESET, TXPMARESET, TXPISOPD}
    localparam logic [2:0] OUT_PWR_WAIT  = 3'b101;
    localparam logic [2:0] OUT_PISO_REL  = 3'b100;
    localparam logic [2:0] OUT_RST_HOLD  = 3'b100;
    localparam logic [2:0] OUT_PMA_HOLD  = 3'b010;
    localparam logic [2:0] OUT_WAIT_DONE = 3'b000;
    localparam logic [2:0] OUT_DONE      = 3'b000;
    localparam logic [2:0] OUT_FAIL      = 3'b100;

    function automatic logic [2:0] state_outputs(input tx_state_e s);
        logic [2:0] o;
        case (s)
            ST_PWR_WAIT:  o = OUT_PWR_WAIT;
            ST_PISO_REL:  o = OUT_PISO_REL;
            ST_RST_HOLD:  o = OUT_RST_HOLD;
            ST_PMA_HOLD:  o = OUT_PMA_HOLD;
            ST_WAIT_DONE: o = OUT_WAIT_DONE;
            ST_DONE:      o = OUT_DONE;
            ST_FAIL:      o = OUT_FAIL;
            default:      o = OUT_PWR_WAIT;
        endcase
        return o;
    endfunction

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gtfwizard_mac_sync_bit.sv
// Single-bit multi-flop synchronizer into the free-running clock domain.
// Kept as discrete flops so the tools neither merge them nor map them to SRLs.
module gtfwizard_mac_sync_bit #(
    parameter int C_SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [C_SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[C_SYNC_STAGES-2:0], din};
        end
    end

    assign dout = sync_ff[C_SYNC_STAGES-1];

endmodule

// File: rtl/gtfwizard_mac_tx_reset_sequencer.sv
// GTF transmitter bring-up sequencer: power-good wait, PISO release, GTTXRESET
// hold/release, TXRESETDONE timeout with bounded retry, and user reset requests.
module gtfwizard_mac_tx_reset_sequencer
    import gtfwizard_mac_tx_rst_pkg::*;
#(
    parameter int C_SYNC_STAGES = 3,
    parameter int C_PISO_WAIT   = 16,
    parameter int C_RST_HOLD    = 32,
    parameter int C_TIMEOUT     = 4096,
    parameter int C_MAX_RETRY   = 3
) (
    input  logic                             FREERUN_CLK,
    input  logic                             FREERUN_RST_N,
    input  logic                             USER_GTPOWERGOOD,
    input  logic                             GT_TXRESETDONE,
    input  logic                             USER_TX_RESET_REQ,
    input  logic                             USER_TX_PMA_RESET_REQ,
    output logic                             USER_GTTXRESET,
    output logic                             USER_TXPMARESET,
    output logic                             USER_TXPISOPD,
    output logic                             TX_RESET_DONE,
    output logic                             TX_RESET_FAIL,
    output logic [$clog2(C_MAX_RETRY+1)-1:0] TX_RETRY_CNT
);

    localparam int CNT_W = cnt_width(C_PISO_WAIT, C_RST_HOLD, C_TIMEOUT);
    localparam int RTY_W = $clog2(C_MAX_RETRY + 1);

    // Each wait loads N-1 so the state lasts exactly N cycles before moving on
    localparam logic [CNT_W-1:0] LD_PISO = CNT_W'(C_PISO_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(C_RST_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_TMO  = CNT_W'(C_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(C_MAX_RETRY);

    logic             pg_s;
    logic             done_s;
    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [RTY_W-1:0] retry;
    logic [RTY_W-1:0] retry_nxt;
    logic             reload;

    gtfwizard_mac_sync_bit #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_sync_pg (
        .clk   (FREERUN_CLK),
        .rst_n (FREERUN_RST_N),
        .din   (USER_GTPOWERGOOD),
        .dout  (pg_s)
    );

    gtfwizard_mac_sync_bit #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_sync_done (
        .clk   (FREERUN_CLK),
        .rst_n (FREERUN_RST_N),
        .din   (GT_TXRESETDONE),
        .dout  (done_s)
    );

    always_comb begin
        state_nxt = state;
        retry_nxt = retry;
        reload    = 1'b0;
        if (!pg_s) begin
            state_nxt = ST_PWR_WAIT;
            retry_nxt = '0;
        end else if (USER_TX_RESET_REQ && (state != ST_PWR_WAIT) && (state != ST_PISO_REL)) begin
            state_nxt = ST_RST_HOLD;
            retry_nxt = '0;
            reload    = 1'b1;
        end else if (USER_TX_PMA_RESET_REQ &&
                     (state inside {ST_WAIT_DONE, ST_DONE, ST_FAIL, ST_PMA_HOLD})) begin
            // PMA_HOLD is included so a held request keeps reloading the hold time
            state_nxt = ST_PMA_HOLD;
            retry_nxt = '0;
            reload    = 1'b1;
        end else begin
            case (state)
                ST_PWR_WAIT: state_nxt = ST_PISO_REL;
                ST_PISO_REL: begin
                    if (cnt == '0) begin
                        state_nxt = ST_RST_HOLD;
                        retry_nxt = '0;
                    end
                end
                ST_RST_HOLD, ST_PMA_HOLD: begin
                    if (cnt == '0) begin
                        state_nxt = ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // Reset-done is checked first so it wins a same-cycle timeout
                    if (done_s) begin
                        state_nxt = ST_DONE;
                    end else if (cnt == '0) begin
                        if (retry < RTY_MAX) begin
                            state_nxt = ST_RST_HOLD;
                            retry_nxt = retry + RTY_W'(1);
                        end else begin
                            state_nxt = ST_FAIL;
                        end
                    end
                end
                ST_DONE: begin
                    if (!done_s) begin
                        state_nxt = ST_RST_HOLD;
                        retry_nxt = '0;
                    end
                end
                ST_FAIL: state_nxt = ST_FAIL;
                default: state_nxt = ST_PWR_WAIT;
            endcase
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if ((state_nxt != state) || reload) begin
            case (state_nxt)
                ST_PISO_REL:              cnt_nxt = LD_PISO;
                ST_RST_HOLD, ST_PMA_HOLD: cnt_nxt = LD_HOLD;
                ST_WAIT_DONE:             cnt_nxt = LD_TMO;
                default:                  cnt_nxt = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge FREERUN_CLK or negedge FREERUN_RST_N) begin
        if (!FREERUN_RST_N) begin
            state           <= ST_PWR_WAIT;
            cnt             <= '0;
            retry           <= '0;
            USER_GTTXRESET  <= 1'b1;
            USER_TXPMARESET <= 1'b0;
            USER_TXPISOPD   <= 1'b1;
            TX_RESET_DONE   <= 1'b0;
            TX_RESET_FAIL   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            retry <= retry_nxt;
            {USER_GTTXRESET, USER_TXPMARESET, USER_TXPISOPD} <= state_outputs(state_nxt);
            TX_RESET_DONE <= (state_nxt == ST_DONE);
            TX_RESET_FAIL <= (state_nxt == ST_FAIL);
        end
    end

    assign TX_RETRY_CNT = retry;

endmodule

// File: tb/tb_gtfwizard_mac_tx_reset_sequencer.sv
// Directed bench with randomized delays; expected output vectors come from the
// sequence's timing rules expressed as cycle arithmetic on the configuration.
module tb_gtfwizard_mac_tx_reset_sequencer;

    localparam int SYNC = 3;
    localparam int PISO = 16;
    localparam int HOLD = 32;
    localparam int TMO  = 4096;
    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pg = 1'b0;
    logic       txdone = 1'b0;
    logic       req = 1'b0;
    logic       pma_req = 1'b0;
    logic       gttxreset;
    logic       txpmareset;
    logic       txpisopd;
    logic       tx_done;
    logic       tx_fail;
    logic [1:0] retry_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gtfwizard_mac_tx_reset_sequencer #(
        .C_SYNC_STAGES (SYNC),
        .C_PISO_WAIT   (PISO),
        .C_RST_HOLD    (HOLD),
        .C_TIMEOUT     (TMO),
        .C_MAX_RETRY   (MAXR)
    ) dut (
        .FREERUN_CLK           (clk),
        .FREERUN_RST_N         (rst_n),
        .USER_GTPOWERGOOD      (pg),
        .GT_TXRESETDONE        (txdone),
        .USER_TX_RESET_REQ     (req),
        .USER_TX_PMA_RESET_REQ (pma_req),
        .USER_GTTXRESET        (gttxreset),
        .USER_TXPMARESET       (txpmareset),
        .USER_TXPISOPD         (txpisopd),
        .TX_RESET_DONE         (tx_done),
        .TX_RESET_FAIL         (tx_fail),
        .TX_RETRY_CNT          (retry_cnt)
    );

    // Vector order: {GTTXRESET, TXPMARESET, TXPISOPD, DONE, FAIL, RETRY[1:0]}
    function automatic logic [6:0] expect_vec(input bit g, input bit p, input bit s,
                                              input bit d, input bit f, input int r);
        return {g, p, s, d, f, 2'(r)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit p, input bit d, input bit r, input bit m);
        pg      = p;
        txdone  = d;
        req     = r;
        pma_req = m;
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] expected);
        logic [6:0] observed;
        observed = {gttxreset, txpmareset, txpisopd, tx_done, tx_fail, retry_cnt};
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [6:0] v_pwr;
        logic [6:0] v_done;
        int idle;
        int dly;
        int held;
        int mid;

        v_pwr  = expect_vec(1, 0, 1, 0, 0, 0);
        v_done = expect_vec(0, 0, 0, 1, 0, 0);

        applyStimulus(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #10;
        checkOutput("reset_values", v_pwr);
        step(2);
        checkOutput("reset_held", v_pwr);
        rst_n = 1'b1;
        step(3);
        checkOutput("pwr_wait_idle", v_pwr);

        // Bring-up: power-good, PISO release, reset hold, reset-done
        idle = int'($urandom_range(2, 20));
        step(idle);
        applyStimulus(1, 0, 0, 0);
        step(SYNC);
        checkOutput("pg_latency_pre", v_pwr);
        step(1);
        checkOutput("pisopd_release", expect_vec(1, 0, 0, 0, 0, 0));
        step(PISO + HOLD - 1);
        checkOutput("gttxreset_last_high", expect_vec(1, 0, 0, 0, 0, 0));
        step(1);
        checkOutput("gttxreset_fall", expect_vec(0, 0, 0, 0, 0, 0));
        dly = int'($urandom_range(20, 300));
        step(dly);
        applyStimulus(1, 1, 0, 0);
        step(SYNC);
        checkOutput("done_latency_pre", expect_vec(0, 0, 0, 0, 0, 0));
        step(1);
        checkOutput("tx_reset_done", v_done);

        // One-cycle PMA request from DONE; the GT drops reset-done meanwhile
        step(int'($urandom_range(3, 30)));
        applyStimulus(1, 0, 0, 1);
        step(1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("pma_entry", expect_vec(0, 1, 0, 0, 0, 0));
        for (int i = 1; i < HOLD; i++) begin
            step(1);
            checkOutput("pma_hold", expect_vec(0, 1, 0, 0, 0, 0));
        end
        step(1);
        checkOutput("pma_release", expect_vec(0, 0, 0, 0, 0, 0));
        step(int'($urandom_range(5, 100)));
        applyStimulus(1, 1, 0, 0);
        step(SYNC);
        checkOutput("pma_done_pre", expect_vec(0, 0, 0, 0, 0, 0));
        step(1);
        checkOutput("pma_done", v_done);

        // Full request held for several cycles keeps reloading the hold time
        held = int'($urandom_range(2, 10));
        applyStimulus(1, 1, 1, 0);
        step(1);
        checkOutput("req_gttxreset", expect_vec(1, 0, 0, 0, 0, 0));
        step(held - 1);
        applyStimulus(1, 1, 0, 0);
        step(HOLD - 1);
        checkOutput("req_hold_extended", expect_vec(1, 0, 0, 0, 0, 0));
        step(1);
        checkOutput("req_release", expect_vec(0, 0, 0, 0, 0, 0));
        step(1);
        checkOutput("req_done_again", v_done);

        // Reset-done loss restarts the hold; no reset-done leads to retries then give-up
        applyStimulus(1, 0, 0, 0);
        step(SYNC);
        checkOutput("done_loss_pre", v_done);
        step(1);
        for (int k = 0; k <= MAXR; k++) begin
            checkOutput("retry_pulse_start", expect_vec(1, 0, 0, 0, 0, k));
            step(HOLD - 1);
            checkOutput("retry_pulse_end", expect_vec(1, 0, 0, 0, 0, k));
            step(1);
            checkOutput("retry_wait", expect_vec(0, 0, 0, 0, 0, k));
            step(TMO - 1);
            checkOutput("retry_timeout_edge", expect_vec(0, 0, 0, 0, 0, k));
            step(1);
        end
        checkOutput("tx_fail_state", expect_vec(1, 0, 0, 0, 1, MAXR));
        step(5);
        checkOutput("tx_fail_sticky", expect_vec(1, 0, 0, 0, 1, MAXR));

        // One-cycle full request clears the give-up; reset-done then ties with the timeout
        applyStimulus(1, 0, 1, 0);
        step(1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("fail_cleared", expect_vec(1, 0, 0, 0, 0, 0));
        step(HOLD);
        checkOutput("restart_fall", expect_vec(0, 0, 0, 0, 0, 0));
        step(TMO - SYNC - 1);
        applyStimulus(1, 1, 0, 0);
        step(SYNC);
        checkOutput("race_pre", expect_vec(0, 0, 0, 0, 0, 0));
        step(1);
        checkOutput("done_beats_timeout", v_done);

        // Power-good loss mid reset-hold, then a full replay
        applyStimulus(1, 0, 1, 0);
        step(1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("pg_test_hold", expect_vec(1, 0, 0, 0, 0, 0));
        mid = int'($urandom_range(2, 20));
        step(mid);
        applyStimulus(0, 0, 0, 0);
        step(SYNC);
        checkOutput("pg_drop_pre", expect_vec(1, 0, 0, 0, 0, 0));
        step(1);
        checkOutput("pg_drop_pwr_wait", v_pwr);
        step(int'($urandom_range(5, 30)));
        checkOutput("pg_low_idle", v_pwr);
        applyStimulus(1, 0, 0, 0);
        step(SYNC);
        checkOutput("replay_pre", v_pwr);
        step(1);
        checkOutput("replay_pisopd", expect_vec(1, 0, 0, 0, 0, 0));
        step(PISO + HOLD - 1);
        checkOutput("replay_last_high", expect_vec(1, 0, 0, 0, 0, 0));
        step(1);
        checkOutput("replay_fall", expect_vec(0, 0, 0, 0, 0, 0));

        // Asynchronous reset between clock edges while waiting for reset-done
        step(int'($urandom_range(10, 100)));
        checkOutput("pre_async_reset", expect_vec(0, 0, 0, 0, 0, 0));
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", v_pwr);
        step(2);
        checkOutput("async_reset_held", v_pwr);
        rst_n = 1'b1;
        step(2);
        checkOutput("post_reset_idle", v_pwr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gtfwizard_mac_tx_reset_sequencer.md
# gtfwizard_mac_tx_reset_sequencer

Sequences GTF transmitter bring-up after the gated power-good stage. Waits for synchronized power-good, releases PISO power-down, then holds and releases GTTXRESET. Monitors TXRESETDONE with a timeout and bounded retry, and accepts full or PMA-only reset requests from MAC/user logic. Its USER_GTTXRESET/USER_TXPMARESET/USER_TXPISOPD outputs feed the power-good delay stage's user inputs.

## Interface
- C_SYNC_STAGES, 3, flop depth of each input synchronizer (min 2)
- C_PISO_WAIT, 16, cycles between PISOPD release and reset-hold start
- C_RST_HOLD, 32, cycles GTTXRESET (or TXPMARESET) held asserted
- C_TIMEOUT, 4096, cycles allowed in WAIT_DONE before a retry
- C_MAX_RETRY, 3, retries before FAIL
- FREERUN_CLK  in  1  free-running sequencer clock
- FREERUN_RST_N  in  1  asynchronous, active-low reset
- USER_GTPOWERGOOD  in  1  gated power-good, async to FREERUN_CLK
- GT_TXRESETDONE  in  1  GT TX reset done, async
- USER_TX_RESET_REQ  in  1  full TX reset request, level, FREERUN_CLK domain
- USER_TX_PMA_RESET_REQ  in  1  PMA-only reset request, level, FREERUN_CLK domain
- USER_GTTXRESET  out  1  to GTTXRESET
- USER_TXPMARESET  out  1  to TXPMARESET
- USER_TXPISOPD  out  1  to TXPISOPD
- TX_RESET_DONE  out  1  TX path up
- TX_RESET_FAIL  out  1  retries exhausted
- TX_RETRY_CNT  out  $clog2(C_MAX_RETRY+1)  retries used in current attempt

## Operation
- Reset values: USER_GTTXRESET=1, USER_TXPMARESET=0, USER_TXPISOPD=1, TX_RESET_DONE=0, TX_RESET_FAIL=0, TX_RETRY_CNT=0, state PWR_WAIT. All outputs are registered.
- pg_s and done_s are the synchronized USER_GTPOWERGOOD and GT_TXRESETDONE. Synchronizers reset to 0.
- States and outputs (GTTXRESET/TXPMARESET/PISOPD):
  - PWR_WAIT: 1/0/1. On pg_s=1, load the counter and go to PISO_REL.
  - PISO_REL: 1/0/0. After C_PISO_WAIT cycles, go to RST_HOLD with retry=0.
  - RST_HOLD: 1/0/0. After C_RST_HOLD cycles, go to WAIT_DONE.
  - PMA_HOLD: 0/1/0. After C_RST_HOLD cycles, go to WAIT_DONE.
  - WAIT_DONE: 0/0/0. Timeout counter runs.
    - done_s=1: go to DONE.
    - Counter reaches C_TIMEOUT with retry<C_MAX_RETRY: retry+1, go to RST_HOLD.
    - Counter reaches C_TIMEOUT with retry=C_MAX_RETRY: go to FAIL.
  - DONE: 0/0/0, TX_RESET_DONE=1. On done_s=0, go to RST_HOLD with retry=0.
  - FAIL: 1/0/0, TX_RESET_FAIL=1. Stays until a request.
- Priority, highest first:
  1. pg_s=0: go to PWR_WAIT from any state; clear DONE, FAIL and retry.
  2. USER_TX_RESET_REQ=1 in any state except PWR_WAIT/PISO_REL: go to RST_HOLD, retry=0, clear DONE/FAIL. While the request stays high, the state is held in RST_HOLD with the counter reloaded.
  3. USER_TX_PMA_RESET_REQ=1 in WAIT_DONE/DONE/FAIL: go to PMA_HOLD, retry=0, clear DONE/FAIL. Level behaviour matches the full request.
  4. Normal transitions.
- If done_s=1 and the timeout is reached in the same cycle, done_s wins and the state goes to DONE.
- A retry always takes the full RST_HOLD path, even when the attempt started in PMA_HOLD.
- One shared down-counter serves all waits. Width is $clog2(max(C_PISO_WAIT,C_RST_HOLD,C_TIMEOUT)+1). It is loaded on every state entry, so there is no wrap-around.

## Timing
- Async input to internal use: C_SYNC_STAGES cycles. The state change follows one cycle later, and outputs update on that same edge.
- Power-good rise to USER_TXPISOPD=0: C_SYNC_STAGES+1 cycles.
- PISOPD release to GTTXRESET fall: C_PISO_WAIT+C_RST_HOLD cycles, ±1 cycle.
- GTTXRESET high pulse in RST_HOLD: exactly C_RST_HOLD cycles.
- GT_TXRESETDONE rise to TX_RESET_DONE=1: C_SYNC_STAGES+1 cycles.
- Request high to USER_GTTXRESET=1: 1 cycle.
- Asserting FREERUN_RST_N mid-sequence forces all reset values immediately, without waiting for a clock edge.

## Structure
- Package gtfwizard_mac_tx_rst_pkg holds:
  - State enum (3-bit, 7 states) and the per-state output encoding constants.
  - A function for counter width.
- Sub-module gtfwizard_mac_sync_bit: a C_SYNC_STAGES flop chain with ASYNC_REG and no SRL extraction, reset by FREERUN_RST_N, instantiated twice.

## Test plan
- Defaults; FREERUN_RST_N released; USER_GTPOWERGOOD rises at cycle 10; GT_TXRESETDONE rises 100 cycles after GTTXRESET falls -> PISOPD=0 at 14, GTTXRESET falls at 62, TX_RESET_DONE=1 four cycles after GT_TXRESETDONE rises, TX_RETRY_CNT=0.
- GT_TXRESETDONE held 0 -> four GTTXRESET pulses of 32 cycles each, spaced 4096 cycles apart; TX_RETRY_CNT goes 1,2,3; then TX_RESET_FAIL=1 with GTTXRESET=1; a 1-cycle USER_TX_RESET_REQ clears FAIL and restarts the sequence.
- In DONE, USER_TX_PMA_RESET_REQ is pulsed for 1 cycle -> TXPMARESET=1 for 32 cycles, GTTXRESET stays 0, TX_RESET_DONE=0 until done_s returns.
- USER_GTPOWERGOOD drops mid-RST_HOLD -> within 4 cycles the state is PWR_WAIT, PISOPD=1 and GTTXRESET=1; a later return of power-good replays the full sequence.
- GT_TXRESETDONE rises so that done_s reaches 1 in exactly the cycle the timeout expires -> DONE, with no retry counted.
- FREERUN_RST_N asserted during WAIT_DONE -> all outputs return to their reset values asynchronously.
